// File: rtl/display_source_arbiter_pkg.sv
// Shared types and constants for the display source arbiter.
package display_arb_pkg;

  typedef enum logic {LIVE, HOLD} arb_state_e;

  localparam logic [1:0] SRC_LIVE = 2'd0;
  localparam logic [1:0] SRC_TARE = 2'd1;
  localparam logic [1:0] SRC_ERR  = 2'd2;

  localparam int unsigned SIGN_BIT        = 24;
  localparam int unsigned VALUE_W         = 25;
  localparam int unsigned DEFAULT_MAX_MAG = 9_999_999;

  // Message priority: err always wins over tare.
  function automatic logic [1:0] pick_msg(input logic err_req);
    return err_req ? SRC_ERR : SRC_TARE;
  endfunction

endpackage

// File: rtl/display_source_arbiter_if.sv
// Request/ack bundle between the three display requesters and the arbiter.
interface display_source_arbiter_if;
  import display_arb_pkg::*;

  logic               LIVE_VALID;
  logic [VALUE_W-1:0] LIVE_VALUE;
  logic               LIVE_ACK;
  logic               TARE_VALID;
  logic [VALUE_W-1:0] TARE_VALUE;
  logic               TARE_ACK;
  logic               ERR_VALID;
  logic [VALUE_W-1:0] ERR_VALUE;
  logic               ERR_ACK;
  logic [VALUE_W-1:0] SIGNED_INT_DISPLAY;
  logic [1:0]         ACTIVE_SRC;
  logic               UPDATE;

  // Requester side.
  modport master (
    output LIVE_VALID, LIVE_VALUE, TARE_VALID, TARE_VALUE, ERR_VALID, ERR_VALUE,
    input  LIVE_ACK, TARE_ACK, ERR_ACK, SIGNED_INT_DISPLAY, ACTIVE_SRC, UPDATE
  );

  // Arbiter side.
  modport slave (
    input  LIVE_VALID, LIVE_VALUE, TARE_VALID, TARE_VALUE, ERR_VALID, ERR_VALUE,
    output LIVE_ACK, TARE_ACK, ERR_ACK, SIGNED_INT_DISPLAY, ACTIVE_SRC, UPDATE
  );

endinterface

// File: rtl/display_source_arbiter_sanitizer.sv
// Saturates the magnitude to what 7 BCD digits can show and folds -0 into +0.
module display_value_sanitizer
  import display_arb_pkg::*;
#(
  parameter int unsigned MAX_MAG = DEFAULT_MAX_MAG
) (
  input  logic [VALUE_W-1:0] value_i,
  output logic [VALUE_W-1:0] value_o
);

  localparam logic [SIGN_BIT-1:0] MaxMag = MAX_MAG[SIGN_BIT-1:0];

  logic                sign;
  logic [SIGN_BIT-1:0] mag;

  // Clamp magnitude, then normalise negative zero.
  always_comb begin
    sign = value_i[SIGN_BIT];
    mag  = value_i[SIGN_BIT-1:0];
    if (mag > MaxMag) mag = MaxMag;
    if (mag == '0) sign = 1'b0;
    value_o = {sign, mag};
  end

endmodule

// File: rtl/display_source_arbiter.sv
// Shares one signed display driver between live weight, tare and error messages.
// Live samples are rate-limited; granted messages stay up for a fixed hold time.
module display_source_arbiter
  import display_arb_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS = 10_000_000,
  parameter int unsigned HOLD_TICKS    = 50_000_000,
  parameter int unsigned MAX_MAG       = DEFAULT_MAX_MAG
) (
  input logic                     CLK,
  input logic                     RST_N,
  display_source_arbiter_if.slave bus
);

  localparam int unsigned RefW  = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int unsigned HoldW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [RefW-1:0]  RefMax   = RefW'(REFRESH_TICKS - 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_TICKS - 1);

  arb_state_e         state_q, state_d;
  logic [RefW-1:0]    refresh_q, refresh_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [VALUE_W-1:0] disp_q, disp_d;
  logic [1:0]         src_q, src_d;
  logic               live_ack_q, live_ack_d;
  logic               tare_ack_q, tare_ack_d;
  logic               err_ack_q, err_ack_d;
  logic               update_q, update_d;

  logic               live_req, tare_req, err_req;
  logic               load;
  logic [1:0]         grant_sel;
  logic [VALUE_W-1:0] grant_value, clean_value;

  // A request seen while its own ack is high is the one just granted.
  assign live_req = bus.LIVE_VALID && !live_ack_q;
  assign tare_req = bus.TARE_VALID && !tare_ack_q;
  assign err_req  = bus.ERR_VALID  && !err_ack_q;

  // Select the value of the source being granted this cycle.
  always_comb begin
    case (grant_sel)
      SRC_ERR:  grant_value = bus.ERR_VALUE;
      SRC_TARE: grant_value = bus.TARE_VALUE;
      default:  grant_value = bus.LIVE_VALUE;
    endcase
  end

  display_value_sanitizer #(
    .MAX_MAG (MAX_MAG)
  ) u_sanitizer (
    .value_i (grant_value),
    .value_o (clean_value)
  );

  // Arbitration, refresh rate limit and hold timing.
  always_comb begin
    state_d   = state_q;
    refresh_d = refresh_q;
    hold_d    = hold_q;
    src_d     = src_q;
    disp_d    = disp_q;
    load      = 1'b0;
    grant_sel = SRC_LIVE;

    case (state_q)
      LIVE: begin
        if (err_req || tare_req) begin
          grant_sel = pick_msg(err_req);
          load      = 1'b1;
          hold_d    = HoldInit;
          state_d   = HOLD;
        end else if (live_req && (refresh_q == RefMax)) begin
          load      = 1'b1;
          refresh_d = '0;
        end else if (refresh_q != RefMax) begin
          refresh_d = refresh_q + 1'b1;
        end
      end
      HOLD: begin
        if ((src_q == SRC_TARE && err_req) || (hold_q == '0 && (err_req || tare_req))) begin
          grant_sel = pick_msg(err_req);
          load      = 1'b1;
          hold_d    = HoldInit;
        end else if (hold_q == '0) begin
          // Primed so a waiting live sample goes up on the very next cycle.
          state_d   = LIVE;
          src_d     = SRC_LIVE;
          refresh_d = RefMax;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = LIVE;
    endcase

    if (load) begin
      src_d  = grant_sel;
      disp_d = clean_value;
    end
    live_ack_d = load && (grant_sel == SRC_LIVE);
    tare_ack_d = load && (grant_sel == SRC_TARE);
    err_ack_d  = load && (grant_sel == SRC_ERR);
    update_d   = load;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= LIVE;
      refresh_q  <= RefMax;
      hold_q     <= '0;
      disp_q     <= '0;
      src_q      <= SRC_LIVE;
      live_ack_q <= 1'b0;
      tare_ack_q <= 1'b0;
      err_ack_q  <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      refresh_q  <= refresh_d;
      hold_q     <= hold_d;
      disp_q     <= disp_d;
      src_q      <= src_d;
      live_ack_q <= live_ack_d;
      tare_ack_q <= tare_ack_d;
      err_ack_q  <= err_ack_d;
      update_q   <= update_d;
    end
  end

  assign bus.SIGNED_INT_DISPLAY = disp_q;
  assign bus.ACTIVE_SRC         = src_q;
  assign bus.LIVE_ACK           = live_ack_q;
  assign bus.TARE_ACK           = tare_ack_q;
  assign bus.ERR_ACK            = err_ack_q;
  assign bus.UPDATE             = update_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter with short refresh/hold times.
module tb_display_source_arbiter;

  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

  display_source_arbiter_if bus ();

  display_source_arbiter #(
    .REFRESH_TICKS (4),
    .HOLD_TICKS    (8),
    .MAX_MAG       (9_999_999)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N          = 1'b0;
    bus.LIVE_VALID = 1'b1;
    bus.LIVE_VALUE = 25'd1234;
    bus.TARE_VALID = 1'b0;
    bus.TARE_VALUE = '0;
    bus.ERR_VALID  = 1'b0;
    bus.ERR_VALUE  = '0;
    step();
    step();
    checks++;
    if (bus.SIGNED_INT_DISPLAY !== 25'd0) begin
      failures++;
      $display("FAIL reset_display: got %0h expected 0", bus.SIGNED_INT_DISPLAY);
    end
    checks++;
    if ({bus.ACTIVE_SRC, bus.LIVE_ACK, bus.TARE_ACK, bus.ERR_ACK, bus.UPDATE} !== 6'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got src=%0d acks=%b%b%b upd=%b expected all 0", bus.ACTIVE_SRC,
               bus.LIVE_ACK, bus.TARE_ACK, bus.ERR_ACK, bus.UPDATE);
    end
  endtask

  task automatic test_live_rate();
    int n;
    RST_N = 1'b1;
    step();
    checks++;
    if (bus.LIVE_ACK !== 1'b1 || bus.UPDATE !== 1'b1 || bus.SIGNED_INT_DISPLAY !== 25'd1234 ||
        bus.ACTIVE_SRC !== 2'd0) begin
      failures++;
      $display("FAIL first_live: got ack=%b upd=%b disp=%0d src=%0d expected 1 1 1234 0",
               bus.LIVE_ACK, bus.UPDATE, bus.SIGNED_INT_DISPLAY, bus.ACTIVE_SRC);
    end
    bus.LIVE_VALUE = 25'd1240;
    n = 0;
    do begin step(); n++; end while (bus.LIVE_ACK !== 1'b1 && n < 20);
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL live_refresh_gap: got %0d cycles expected 4", n);
    end
    checks++;
    if (bus.SIGNED_INT_DISPLAY !== 25'd1240) begin
      failures++;
      $display("FAIL live_second_value: got %0d expected 1240", bus.SIGNED_INT_DISPLAY);
    end
  endtask

  task automatic test_tare_hold();
    bus.LIVE_VALUE = 25'd1250;
    bus.TARE_VALID = 1'b1;
    bus.TARE_VALUE = 25'd0;
    step();
    checks++;
    if (bus.TARE_ACK !== 1'b1 || bus.LIVE_ACK !== 1'b0 || bus.ACTIVE_SRC !== 2'd1 ||
        bus.SIGNED_INT_DISPLAY !== 25'd0 || bus.UPDATE !== 1'b1) begin
      failures++;
      $display("FAIL tare_grant: got tack=%b lack=%b src=%0d disp=%0d upd=%b expected 1 0 1 0 1",
               bus.TARE_ACK, bus.LIVE_ACK, bus.ACTIVE_SRC, bus.SIGNED_INT_DISPLAY, bus.UPDATE);
    end
    bus.TARE_VALID = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (bus.ACTIVE_SRC !== 2'd1 || bus.SIGNED_INT_DISPLAY !== 25'd0 || bus.LIVE_ACK !== 1'b0) begin
        failures++;
        $display("FAIL tare_held_%0d: got src=%0d disp=%0d lack=%b expected 1 0 0", i,
                 bus.ACTIVE_SRC, bus.SIGNED_INT_DISPLAY, bus.LIVE_ACK);
      end
    end
    step();
    checks++;
    if (bus.ACTIVE_SRC !== 2'd0 || bus.LIVE_ACK !== 1'b0 || bus.SIGNED_INT_DISPLAY !== 25'd0) begin
      failures++;
      $display("FAIL tare_expiry: got src=%0d lack=%b disp=%0d expected 0 0 0", bus.ACTIVE_SRC,
               bus.LIVE_ACK, bus.SIGNED_INT_DISPLAY);
    end
    step();
    checks++;
    if (bus.LIVE_ACK !== 1'b1 || bus.SIGNED_INT_DISPLAY !== 25'd1250) begin
      failures++;
      $display("FAIL live_after_tare: got lack=%b disp=%0d expected 1 1250", bus.LIVE_ACK,
               bus.SIGNED_INT_DISPLAY);
    end
    bus.LIVE_VALID = 1'b0;
  endtask

  task automatic test_err_preempt();
    int n;
    bus.TARE_VALID = 1'b1;
    bus.TARE_VALUE = 25'd500;
    step();
    checks++;
    if (bus.TARE_ACK !== 1'b1 || bus.SIGNED_INT_DISPLAY !== 25'd500) begin
      failures++;
      $display("FAIL tare_before_err: got tack=%b disp=%0d expected 1 500", bus.TARE_ACK,
               bus.SIGNED_INT_DISPLAY);
    end
    bus.TARE_VALID = 1'b0;
    step();
    step();
    bus.ERR_VALID = 1'b1;
    bus.ERR_VALUE = {1'b1, 24'd42};
    step();
    checks++;
    if (bus.ERR_ACK !== 1'b1 || bus.TARE_ACK !== 1'b0 || bus.ACTIVE_SRC !== 2'd2 ||
        bus.SIGNED_INT_DISPLAY !== {1'b1, 24'd42}) begin
      failures++;
      $display("FAIL err_preempt: got eack=%b tack=%b src=%0d disp=%0h expected 1 0 2 100002a",
               bus.ERR_ACK, bus.TARE_ACK, bus.ACTIVE_SRC, bus.SIGNED_INT_DISPLAY);
    end
    bus.ERR_VALID  = 1'b0;
    bus.TARE_VALID = 1'b1;
    bus.TARE_VALUE = 25'd77;
    n = 0;
    do begin step(); n++; end while (bus.TARE_ACK !== 1'b1 && n < 20);
    checks++;
    if (n != 8 || bus.ACTIVE_SRC !== 2'd1 || bus.SIGNED_INT_DISPLAY !== 25'd77) begin
      failures++;
      $display("FAIL tare_after_err: got cycles=%0d src=%0d disp=%0d expected 8 1 77", n,
               bus.ACTIVE_SRC, bus.SIGNED_INT_DISPLAY);
    end
    bus.TARE_VALID = 1'b0;
    n = 0;
    do begin step(); n++; end while (bus.ACTIVE_SRC !== 2'd0 && n < 20);
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL err_chain_expiry: got %0d cycles expected 8", n);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bus.ERR_VALID  = 1'b1;
    bus.ERR_VALUE  = 25'd3;
    bus.TARE_VALID = 1'b1;
    bus.TARE_VALUE = 25'd5;
    step();
    checks++;
    if (bus.ERR_ACK !== 1'b1 || bus.TARE_ACK !== 1'b0 || bus.ACTIVE_SRC !== 2'd2 ||
        bus.SIGNED_INT_DISPLAY !== 25'd3) begin
      failures++;
      $display("FAIL simul_err_first: got eack=%b tack=%b src=%0d disp=%0d expected 1 0 2 3",
               bus.ERR_ACK, bus.TARE_ACK, bus.ACTIVE_SRC, bus.SIGNED_INT_DISPLAY);
    end
    bus.ERR_VALID = 1'b0;
    n = 0;
    do begin step(); n++; end while (bus.TARE_ACK !== 1'b1 && n < 20);
    checks++;
    if (n != 8 || bus.ACTIVE_SRC !== 2'd1 || bus.SIGNED_INT_DISPLAY !== 25'd5) begin
      failures++;
      $display("FAIL simul_tare_second: got cycles=%0d src=%0d disp=%0d expected 8 1 5", n,
               bus.ACTIVE_SRC, bus.SIGNED_INT_DISPLAY);
    end
    bus.TARE_VALID = 1'b0;
    n = 0;
    do begin step(); n++; end while (bus.ACTIVE_SRC !== 2'd0 && n < 20);
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL simul_back_to_live: got %0d cycles expected 8", n);
    end
  endtask

  task automatic test_sanitize();
    int n;
    bus.LIVE_VALID = 1'b1;
    bus.LIVE_VALUE = {1'b1, 24'd16_000_000};
    n = 0;
    do begin step(); n++; end while (bus.LIVE_ACK !== 1'b1 && n < 20);
    checks++;
    if (n != 1 || bus.SIGNED_INT_DISPLAY !== {1'b1, 24'd9_999_999}) begin
      failures++;
      $display("FAIL sat_negative: got cycles=%0d disp=%0h expected 1 %0h", n,
               bus.SIGNED_INT_DISPLAY, {1'b1, 24'd9_999_999});
    end
    bus.LIVE_VALUE = {1'b1, 24'd0};
    n = 0;
    do begin step(); n++; end while (bus.LIVE_ACK !== 1'b1 && n < 20);
    checks++;
    if (n != 4 || bus.SIGNED_INT_DISPLAY !== 25'd0) begin
      failures++;
      $display("FAIL neg_zero: got cycles=%0d disp=%0h expected 4 0", n, bus.SIGNED_INT_DISPLAY);
    end
    bus.LIVE_VALUE = {1'b0, 24'hFF_FFFF};
    n = 0;
    do begin step(); n++; end while (bus.LIVE_ACK !== 1'b1 && n < 20);
    checks++;
    if (bus.SIGNED_INT_DISPLAY !== {1'b0, 24'd9_999_999}) begin
      failures++;
      $display("FAIL sat_positive: got %0h expected %0h", bus.SIGNED_INT_DISPLAY,
               {1'b0, 24'd9_999_999});
    end
    bus.LIVE_VALID = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    bus.ERR_VALID = 1'b1;
    bus.ERR_VALUE = 25'd9;
    step();
    checks++;
    if (bus.ERR_ACK !== 1'b1 || bus.ACTIVE_SRC !== 2'd2) begin
      failures++;
      $display("FAIL pre_reset_err: got eack=%b src=%0d expected 1 2", bus.ERR_ACK,
               bus.ACTIVE_SRC);
    end
    bus.ERR_VALID  = 1'b0;
    bus.TARE_VALID = 1'b1;
    bus.TARE_VALUE = 25'd123;
    step();
    step();
    RST_N = 1'b0;
    step();
    checks++;
    if (bus.SIGNED_INT_DISPLAY !== 25'd0 || bus.ACTIVE_SRC !== 2'd0 || bus.TARE_ACK !== 1'b0 ||
        bus.ERR_ACK !== 1'b0 || bus.LIVE_ACK !== 1'b0 || bus.UPDATE !== 1'b0) begin
      failures++;
      $display("FAIL mid_hold_reset: got disp=%0d src=%0d tack=%b eack=%b upd=%b expected all 0",
               bus.SIGNED_INT_DISPLAY, bus.ACTIVE_SRC, bus.TARE_ACK, bus.ERR_ACK, bus.UPDATE);
    end
    RST_N = 1'b1;
    step();
    checks++;
    if (bus.TARE_ACK !== 1'b1 || bus.ACTIVE_SRC !== 2'd1 || bus.SIGNED_INT_DISPLAY !== 25'd123) begin
      failures++;
      $display("FAIL tare_after_reset: got tack=%b src=%0d disp=%0d expected 1 1 123",
               bus.TARE_ACK, bus.ACTIVE_SRC, bus.SIGNED_INT_DISPLAY);
    end
    bus.TARE_VALID = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_live_rate();
    test_tare_hold();
    test_err_preempt();
    test_simultaneous();
    test_sanitize();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
